// File: rtl/fft8_frame_ctrl_if.sv
// Sample-in / bin-out streams of the 8-point FFT frame sequencer.
// master = surrounding system, slave = the sequencer.
interface fft8_frame_ctrl_if #(
    parameter int DW = 9
) ();

    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;

    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [2:0]    out_idx;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_re,
        input  out_im,
        input  out_idx,
        input  out_valid,
        input  out_last,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_re,
        output out_im,
        output out_idx,
        output out_valid,
        output out_last,
        input  out_ready
    );

endinterface

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 8-point radix-2 DIT FFT core:
// fill 8 samples, settle, then walk bins 0..7 out over valid/ready.
module fft8_frame_ctrl #(
    parameter int DW     = 9,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             abort,
    fft8_frame_ctrl_if.slave s,
    output logic [8*DW-1:0]  frame_x,
    output logic [2:0]       fft_sel,
    input  logic [DW-1:0]    fft_yr,
    input  logic [DW-1:0]    fft_yi,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt
);

    // A settle time of zero still needs one cycle in SETTLE.
    localparam int SET_LD = (SETTLE < 1) ? 1 : SETTLE;
    localparam int SW     = $clog2(SET_LD + 1);

    localparam logic [SW-1:0]    SET_INIT = SW'(SET_LD);
    localparam logic [SW-1:0]    SET_ONE  = SW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       LAST_K   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SETTLE,
        S_SEL,
        S_WAIT,
        S_PRESENT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       wr_q;
    logic [2:0]       wr_d;
    logic [2:0]       k_q;
    logic [2:0]       k_d;
    logic [SW-1:0]    cnt_q;
    logic [SW-1:0]    cnt_d;
    logic [2:0]       sel_q;
    logic [2:0]       sel_d;
    logic [DW-1:0]    re_q;
    logic [DW-1:0]    re_d;
    logic [DW-1:0]    im_q;
    logic [DW-1:0]    im_d;
    logic [2:0]       idx_q;
    logic [2:0]       idx_d;
    logic             vld_q;
    logic             vld_d;
    logic             last_q;
    logic             last_d;
    logic [CNT_W-1:0] fcnt_q;
    logic [CNT_W-1:0] fcnt_d;
    logic [DW-1:0]    fbuf_q [8];
    logic [DW-1:0]    fbuf_d [8];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wr_q    <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            re_q    <= '0;
            im_q    <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            fcnt_q  <= '0;
            for (int n = 0; n < 8; n++) begin
                fbuf_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            re_q    <= re_d;
            im_q    <= im_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            fcnt_q  <= fcnt_d;
            fbuf_q  <= fbuf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        re_d    = re_q;
        im_d    = im_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        last_d  = last_q;
        fcnt_d  = fcnt_q;
        fbuf_d  = fbuf_q;

        // Abort wins over any handshake in the same cycle.
        if (abort) begin
            state_d = S_IDLE;
            wr_d    = '0;
            k_d     = '0;
            cnt_d   = '0;
            vld_d   = 1'b0;
            last_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_d = S_FILL;
                    end
                end

                S_FILL: begin
                    if (s.in_valid) begin
                        fbuf_d[wr_q] = s.in_data;
                        wr_d         = wr_q + 3'd1;
                        if (wr_q == LAST_K) begin
                            state_d = S_SETTLE;
                            cnt_d   = SET_INIT;
                            wr_d    = '0;
                        end
                    end
                end

                S_SETTLE: begin
                    cnt_d = cnt_q - SET_ONE;
                    if (cnt_q <= SET_ONE) begin
                        state_d = S_SEL;
                        cnt_d   = '0;
                        k_d     = '0;
                        sel_d   = '0;
                    end
                end

                S_SEL: begin
                    state_d = S_WAIT;
                end

                // The core registered bin k on the edge into WAIT.
                S_WAIT: begin
                    re_d    = fft_yr;
                    im_d    = fft_yi;
                    idx_d   = k_q;
                    vld_d   = 1'b1;
                    last_d  = (k_q == LAST_K);
                    state_d = S_PRESENT;
                end

                S_PRESENT: begin
                    if (s.out_ready) begin
                        vld_d  = 1'b0;
                        last_d = 1'b0;
                        if (k_q == LAST_K) begin
                            fcnt_d  = fcnt_q + CNT_ONE;
                            k_d     = '0;
                            state_d = en ? S_FILL : S_IDLE;
                        end else begin
                            k_d     = k_q + 3'd1;
                            sel_d   = k_q + 3'd1;
                            state_d = S_SEL;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        frame_x = '0;
        for (int n = 0; n < 8; n++) begin
            frame_x[n*DW +: DW] = fbuf_q[n];
        end
    end

    assign s.in_ready  = (state_q == S_FILL) && !abort;
    assign s.out_re    = re_q;
    assign s.out_im    = im_q;
    assign s.out_idx   = idx_q;
    assign s.out_valid = vld_q;
    assign s.out_last  = last_q;

    assign busy      = (state_q != S_IDLE) && (state_q != S_FILL);
    assign fft_sel   = sel_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: doc/fft8_frame_ctrl.md
Name: fft8_frame_ctrl

Overview:
- Sequencer for the 8-point radix-2 DIT FFT core.
- Collects 8 streamed 9-bit real samples into a frame buffer and presents them to the core's x0..x7 inputs.
- Waits a programmable settle time for the combinational butterfly network.
- Walks the core's bin-select input 0..7 and streams each registered bin (re, im, index) out over a valid/ready interface.

Parameters:
- DW, 9, sample and bin word width (two's complement).
- SETTLE, 2, cycles the frame is held before the first bin select; a value of 0 is treated as 1.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk_in  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  permits leaving IDLE.
- abort  in  1  synchronous flush back to IDLE.
- in_data  in  DW  input sample.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller accepts a sample (high only in FILL).
- frame_x  out  8*DW  frame to the core; x_n at [n*DW +: DW].
- fft_sel  out  3  bin select to the core.
- fft_yr  in  DW  core real output; registered by the core, valid one edge after fft_sel.
- fft_yi  in  DW  core imaginary output; same timing as fft_yr.
- out_re  out  DW  bin real part.
- out_im  out  DW  bin imaginary part.
- out_idx  out  3  bin index.
- out_valid  out  1  out_* valid.
- out_ready  in  1  sink accepts the bin.
- out_last  out  1  high with out_valid when out_idx==7.
- busy  out  1  state is not IDLE and not FILL.
- frame_cnt  out  CNT_W  count of completed frames; wraps.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - frame buffer, frame_x, fft_sel, out_re, out_im, out_idx, frame_cnt = 0.
  - out_valid, out_last, in_ready, busy = 0.
  - Sample and settle counters = 0.
- States: IDLE, FILL, SETTLE, SEL, WAIT, PRESENT.
- IDLE: goes to FILL when en=1; otherwise stays.
- FILL:
  - in_ready=1.
  - On in_valid & in_ready, write in_data to buffer slot wr_ptr (natural order: first sample to x0) and increment wr_ptr.
  - Accepting the 8th sample (wr_ptr==7) goes to SETTLE, loads settle counter = max(SETTLE,1), and clears wr_ptr.
  - frame_x tracks the buffer continuously; its contents are don't-care until SETTLE.
- SETTLE:
  - Buffer is frozen and in_ready=0.
  - Counter decrements each cycle.
  - At count 1: go to SEL, with bin index k=0.
- SEL: drive fft_sel=k; next state WAIT.
- WAIT:
  - fft_sel held at k; the core has registered bin k on the entering edge.
  - At the end of WAIT, capture out_re<=fft_yr, out_im<=fft_yi, out_idx<=k.
  - Set out_valid=1, and out_last=1 if k==7.
  - Next state PRESENT.
- PRESENT:
  - out_* held stable while out_valid & !out_ready.
  - On handshake: clear out_valid and out_last.
    - If k<7: k+1, go to SEL.
    - If k==7: frame_cnt+1, go to FILL (or to IDLE if en=0).
- Throughput: 3 cycles per bin with out_ready held high. Bin 0 leaves SETTLE+3 cycles after the 8th input handshake.
- Frame buffer and frame_x are held unchanged from SETTLE through the final PRESENT handshake.
- No samples are accepted outside FILL; no ping-pong buffering.
- abort=1 at any state:
  - Next cycle: IDLE, with out_valid, out_last, in_ready = 0.
  - wr_ptr, k, settle counter cleared. A partially filled frame is discarded.
  - frame_cnt and the buffer contents are retained.
  - abort takes priority over a simultaneous handshake; that handshake is not counted.
- fft_sel changes only on the SEL entry edge; it holds its last value elsewhere.
- frame_cnt wraps from 2^CNT_W-1 to 0.
- Reset mid-operation returns to IDLE immediately, with all outputs at reset values.

Test Plan:
- Impulse: en=1, samples 1,0,0,0,0,0,0,0, out_ready=1 -> 8 bins with idx 0..7, re=1 and im=0 for all; out_last only on idx 7; frame_cnt=1.
- Alternating: samples 1,0,1,0,1,0,1,0 -> re = 4,0,0,0,4,0,0,0, im=0. Bin 0 out_valid exactly SETTLE+3 cycles after the 8th input handshake; bins then 3 cycles apart.
- Backpressure: out_ready low for 5 cycles while the idx 3 bin is presented -> out_re, out_im, out_idx stay 3's values and fft_sel stays 3. Then resume -> no bin lost or duplicated; in_ready=0 throughout.
- Input gaps: in_valid toggles randomly during FILL -> only 8 handshakes are taken; the 9th offered sample is not accepted until the next FILL. Two back-to-back frames -> frame_cnt=2.
- Abort/reset:
  - abort during PRESENT of idx 5 -> IDLE next cycle, out_valid=0, frame_cnt unchanged. A new frame then starts at x0.
  - rst_n low mid-FILL after 4 samples -> all outputs at reset values asynchronously; after release, IDLE then FILL with wr_ptr=0.
- en=0 at frame end -> IDLE after the last handshake, in_ready=0. Re-asserting en returns to FILL in one cycle.
